// File: rtl/cpu_sram_arb.sv
// cpu_sram_arb: arbitrates the fetch (inst) and load/store (data) sram-like
// ports onto one shared sram-like memory port. Data wins by default, inst
// wins once it has been starved for STARVE_LIM cycles. A stalled offer is
// held until the memory accepts it. Responses are steered back in order
// through a small tag FIFO.
module cpu_sram_arb #(
  parameter int unsigned MAX_OUT    = 2,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  input  logic [3:0]  inst_wstrb,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,

  output logic        arb_busy
);

  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);
  localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int unsigned DEPTH = 1 << PTR_W;
  localparam int unsigned SC_W  = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUT);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUT - 1);
  localparam logic [SC_W-1:0]  SC_MAX   = SC_W'(STARVE_LIM);

  // Request payload carried from either source to the memory port.
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } sram_req_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_I = 2'd1,
    HOLD_D = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              sel_data;
  logic              src_req;
  logic              not_full;
  logic              accept;
  logic              pop;
  logic              head_tag;
  sram_req_t         inst_pl;
  sram_req_t         data_pl;
  sram_req_t         mem_pl;

  logic [CNT_W-1:0]  count_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [DEPTH-1:0]  tag_q;
  logic [SC_W-1:0]   starve_q;

  // Pointer advance that wraps at MAX_OUT rather than at the power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign inst_pl = {inst_wr, inst_size, inst_addr, inst_wdata, inst_wstrb};
  assign data_pl = {data_wr, data_size, data_addr, data_wdata, data_wstrb};

  // Payload mux onto the shared port; don't-care whenever mem_req is low.
  assign mem_pl = sel_data ? data_pl : inst_pl;
  assign {mem_wr, mem_size, mem_addr, mem_wdata, mem_wstrb} = mem_pl;

  // Read data is broadcast; the data_ok strobes say who owns it.
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

  assign not_full = (count_q < CNT_MAX);
  assign arb_busy = (count_q != '0);

  // Response steering: a strobe with nothing outstanding is dropped.
  assign pop          = mem_data_ok && (count_q != '0);
  assign head_tag     = tag_q[rd_ptr_q];
  assign inst_data_ok = pop && !head_tag;
  assign data_data_ok = pop && head_tag;

  // Grant state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Source selection, shared-port request, accept strobes and next state.
  always_comb begin
    state_d      = state_q;
    sel_data     = 1'b0;
    src_req      = 1'b0;
    mem_req      = 1'b0;
    accept       = 1'b0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;

    case (state_q)
      HOLD_I:  sel_data = 1'b0;
      HOLD_D:  sel_data = 1'b1;
      default: sel_data = data_req && !(inst_req && (starve_q == SC_MAX));
    endcase

    src_req      = sel_data ? data_req : inst_req;
    mem_req      = src_req && not_full && resetn;
    accept       = mem_req && mem_addr_ok;
    inst_addr_ok = accept && !sel_data;
    data_addr_ok = accept && sel_data;

    case (state_q)
      IDLE: begin
        if (mem_req && !mem_addr_ok) begin
          state_d = sel_data ? HOLD_D : HOLD_I;
        end
      end
      // A held source that withdraws its request releases the hold.
      HOLD_I: begin
        if (accept || !inst_req) begin
          state_d = IDLE;
        end
      end
      HOLD_D: begin
        if (accept || !data_req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Tag FIFO and outstanding count: push on accept, pop on a valid return.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tag_q    <= '0;
    end else begin
      if (accept) begin
        tag_q[wr_ptr_q] <= sel_data;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({accept, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Starvation counter: cycles inst has asked without being accepted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_q <= '0;
    end else if (inst_req && !inst_addr_ok) begin
      starve_q <= (starve_q == SC_MAX) ? starve_q : starve_q + SC_W'(1);
    end else begin
      starve_q <= '0;
    end
  end

endmodule

// File: doc/cpu_sram_arb.md
CPU_SRAM_ARB -- requirements
Module: cpu_sram_arb

Interface
REQ-001 SHALL have parameter MAX_OUT, default 2, meaning the maximum number of accepted requests awaiting data_ok (legal range 1..4).
REQ-002 SHALL have parameter STARVE_LIM, default 4, meaning the number of consecutive inst-denied cycles that forces an inst grant.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have inst request ports inst_req/inst_wr/inst_size/inst_addr/inst_wdata/inst_wstrb  input  1/1/2/32/32/4  fetch-side sram-like request.
REQ-006 SHALL have inst response ports inst_addr_ok/inst_data_ok/inst_rdata  output  1/1/32  fetch-side accept, return and read data.
REQ-007 SHALL have data request ports data_req/data_wr/data_size/data_addr/data_wdata/data_wstrb  input  1/1/2/32/32/4  load/store sram-like request.
REQ-008 SHALL have data response ports data_addr_ok/data_data_ok/data_rdata  output  1/1/32  load/store accept, return and read data.
REQ-009 SHALL have memory request ports mem_req/mem_wr/mem_size/mem_addr/mem_wdata/mem_wstrb  output  1/1/2/32/32/4  single shared sram-like port.
REQ-010 SHALL have memory response ports mem_addr_ok/mem_data_ok/mem_rdata  input  1/1/32  shared-port accept, return and read data.
REQ-011 SHALL have port arb_busy  output  1  high while the outstanding count is nonzero.

Function
REQ-012 Handshake SHALL be: a request is accepted in a cycle with mem_req && mem_addr_ok; each accepted request returns exactly one mem_data_ok, in order.
REQ-013 Grant FSM states SHALL be IDLE, HOLD_I and HOLD_D; in IDLE a source is selected combinationally in that cycle.
REQ-014 Selection in IDLE SHALL give data priority over inst, except when the starvation counter equals STARVE_LIM, in which case inst wins.
REQ-015 If mem_req is driven with no mem_addr_ok, the FSM SHALL move to HOLD_I or HOLD_D (matching the selected source) and keep that source's fields on mem_* until it is accepted; it returns to IDLE on acceptance.
REQ-016 In a HOLD state, a higher-priority request SHALL NOT pre-empt the held source.
REQ-017 mem_req SHALL equal (selected or held source's req) && (count < MAX_OUT); mem_wr/size/addr/wdata/wstrb SHALL be muxed from that source, and are don't-care when mem_req=0.
REQ-018 x_addr_ok SHALL be mem_addr_ok && mem_req && (x is the selected/held source); the other source's addr_ok SHALL be 0.
REQ-019 On acceptance, a 1-bit tag (0=inst, 1=data) SHALL be pushed into a MAX_OUT-deep tag FIFO, and count SHALL increment.
REQ-020 On mem_data_ok with count>0, the head tag SHALL be popped, inst_data_ok or data_data_ok SHALL be asserted combinationally in the same cycle, and count SHALL decrement.
REQ-021 inst_rdata and data_rdata SHALL both equal mem_rdata at all times.
REQ-022 Simultaneous push and pop SHALL leave count unchanged, with the FIFO pointers both advancing and wrapping modulo MAX_OUT.
REQ-023 Full (count==MAX_OUT) SHALL force mem_req=0 and both addr_ok=0; the FSM state SHALL be retained.
REQ-024 A mem_data_ok with count==0 SHALL be ignored: no x_data_ok, and count stays 0.
REQ-025 Zero-latency response SHALL be supported: acceptance and data_ok in the same cycle for different requests are legal, and a request's own data_ok arrives no earlier than the cycle after its acceptance.
REQ-026 Starvation counter SHALL increment (saturating at STARVE_LIM) each cycle inst_req=1 without inst_addr_ok, and clear on inst_addr_ok or when inst_req=0.
REQ-027 arb_busy SHALL equal (count != 0).

Reset
REQ-028 resetn=0 SHALL asynchronously force FSM=IDLE, count=0, FIFO pointers=0, starvation counter=0; mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, arb_busy SHALL all be 0 while resetn=0.
REQ-029 Reset asserted mid-transaction SHALL discard all outstanding tags; mem_data_ok arriving after reset release for pre-reset requests SHALL be treated per REQ-024.
REQ-030 Reset release SHALL be synchronous to clk; the first grant is possible in the first cycle after resetn rises.

Verification
REQ-031 inst_req=1, data_req=1, mem_addr_ok=1 in one cycle -> data_addr_ok=1, inst_addr_ok=0, mem_addr=data_addr; tag FIFO holds 1.
REQ-032 inst_req=1, addr 0x1c000000, mem_addr_ok=0 for 3 cycles, data_req rises at cycle 1 -> mem_addr stays 0x1c000000 (HOLD_I) until mem_addr_ok; data is granted afterwards.
REQ-033 Two accepts (inst then data), then mem_data_ok twice with rdata 0xAAAA0000, 0xBBBB0000 -> inst_data_ok on the first, data_data_ok on the second; count 2->1->0.
REQ-034 Count=2 and both req=1 -> mem_req=0; same-cycle mem_data_ok frees a slot, and the next cycle mem_req=1.
REQ-035 data_req held 1 continuously, inst_req=1, mem_addr_ok=1 each cycle -> inst granted on the 5th cycle (STARVE_LIM=4); counter then clears.
REQ-036 resetn pulsed low with count=2 -> count=0, arb_busy=0 immediately; subsequent stray mem_data_ok produces no data_ok.
